// File: rtl/nibble_add_sequencer_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM states,
// slice width and the pass-count helper.
package nibble_add_sequencer_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit adder slice: the only adder inside the sequencer.
module nibble_add_slice
  import nibble_add_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_cout
);

  logic [SLICE_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_cin};
  assign o_s    = w_full[SLICE_W-1:0];
  assign o_cout = w_full[SLICE_W];

endmodule

// File: rtl/nibble_add_sequencer.sv
// Multi-cycle WIDTH-bit add/sub that pushes one nibble per clock through a
// single 4-bit slice, LSB first, with a registered ripple carry.
module nibble_add_sequencer
  import nibble_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = nib_count(WIDTH);
  localparam int KW  = $clog2(NIB);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic               r_mode;
  logic               r_a_msb;
  logic               r_b_msb;
  logic [KW-1:0]      r_k;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [SLICE_W-1:0] w_s;
  logic               w_cout;
  logic               w_last;
  logic [WIDTH-1:0]   w_result;

  nibble_add_slice u_slice (
    .i_a    (r_opa[SLICE_W-1:0]),
    .i_b    (r_opb[SLICE_W-1:0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  assign w_last   = (r_k == KW'(NIB - 1));
  assign w_result = {w_s, r_acc[WIDTH-1:SLICE_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Results are captured on the final RUN edge so they are already valid
  // throughout the DONE cycle, and left untouched otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_mode  <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_mode  <= sub;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1] ^ sub;
            r_k     <= '0;
            r_acc   <= '0;
          end
        end
        ST_RUN: begin
          r_acc   <= w_result;
          r_opa   <= r_opa >> SLICE_W;
          r_opb   <= r_opb >> SLICE_W;
          r_carry <= w_cout;
          r_k     <= r_k + KW'(1);
          if (w_last) begin
            r_sum  <= w_result;
            r_cout <= w_cout ^ r_mode;
            r_ovf  <= (r_a_msb == r_b_msb) && (w_s[SLICE_W-1] != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Scoreboard bench: stimulus pushes expected results computed with plain
// arithmetic; a negedge monitor checks busy/done timing and result values.
module tb_nibble_add_sequencer;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  nibble_add_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           t_done;
  } exp_t;

  exp_t         sb_q[$];
  int           cyc = 0;
  int           busy_from = -10;
  int           busy_to = -10;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf = 1'b0;
  int           checks = 0;
  int           errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic icin, input logic isub);
    exp_t   e;
    longint ua, ub, sa, sb, r, s;
    ua = longint'(ia);
    ub = longint'(ib);
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    if (!isub) begin
      r      = ua + ub + longint'(icin);
      e.cout = (r >= (longint'(1) << W));
      s      = sa + sb + longint'(icin);
    end else begin
      r      = ua - ub - longint'(icin);
      e.cout = (ua < ub + longint'(icin));
      s      = sa - sb - longint'(icin);
    end
    e.sum    = r[W-1:0];
    e.ovf    = (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
    e.t_done = 0;
    return e;
  endfunction

  // Monitor: timing expectations come from the busy window the stimulus records.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("reset_outputs", {busy, done, cout, ovf, sum}, '0);
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from) && (cyc <= busy_to)});
      chk("done", {31'd0, done}, {31'd0, cyc == busy_to});
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sum", {16'd0, sum}, {16'd0, e.sum});
          chk("cout", {31'd0, cout}, {31'd0, e.cout});
          chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
          chk("done_cycle", cyc, e.t_done);
          last_sum  = e.sum;
          last_cout = e.cout;
          last_ovf  = e.ovf;
        end
      end else begin
        chk("hold_outputs", {14'd0, cout, ovf, sum}, {14'd0, last_cout, last_ovf, last_sum});
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub, input bit keep);
    exp_t e;
    while (cyc <= busy_to) @(negedge clk);
    a     = ia;
    b     = ib;
    cin   = icin;
    sub   = isub;
    start = 1'b1;
    e        = model(ia, ib, icin, isub);
    e.t_done = cyc + 1 + NIB;
    busy_from = cyc + 1;
    busy_to   = cyc + 1 + NIB;
    sb_q.push_back(e);
    @(negedge clk);
    if (!keep) start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // start asserted during reset must be ignored
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h2222;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);

    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);

    // second start during RUN is ignored
    issue(16'h00F0, 16'h0F10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    @(negedge clk);
    start = 1'b0;

    // start held high: accepted in every IDLE cycle
    issue(16'h0102, 16'h0304, 1'b1, 1'b0, 1'b1);
    issue(16'hF00F, 16'h0FF0, 1'b0, 1'b1, 1'b1);
    issue(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0);

    // reset in the second RUN cycle abandons the operation
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b1;
    sb_q.delete();
    busy_from = -10;
    busy_to   = -10;
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0));
    end
    start = 1'b0;

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
